subleq_mem_arbiter: RTL and testbench
=====================================

Name: subleq_mem_arbiter

Overview:
Shares the single-port program/data memory between the subleq CPU and a host port (loader/debug).
- Normally the CPU owns memory.
- On a host request, the arbiter asserts the CPU's halt input and waits for the CPU to park in HALT. It then grants the host word-wide reads and writes, and releases the CPU after a guaranteed minimum run window.
- Sits between subleq_cpu, the memory macro and the host bridge.

Parameters:
WORD_SIZE, 16, data/address width; must match the CPU word size.
MIN_CPU_CYCLES, 4, number of cycles the CPU runs unhalted after a host burst before the next halt may be requested; 0 disables the window.

Ports:
clk  in  1  clock, all state updates on rising edge
areset  in  1  asynchronous active-high reset
cpu_halt  out  1  to CPU halt input
cpu_halted  in  1  high while the CPU controller is in its HALT state
cpu_load  in  1  CPU load output; 0 = store cycle
cpu_addr  in  WORD_SIZE  CPU address
cpu_wdata  in  WORD_SIZE  CPU store data (its data_out)
cpu_rdata  out  WORD_SIZE  to CPU data_in; always equals mem_rdata
host_req  in  1  level request; host_we/host_addr/host_wdata stable while high
host_we  in  1  1 = write, 0 = read
host_addr  in  WORD_SIZE  host address
host_wdata  in  WORD_SIZE  host write data
host_grant  out  1  host owns memory
host_ack  out  1  one-cycle completion pulse, registered
host_rdata  out  WORD_SIZE  registered read data
mem_addr  out  WORD_SIZE  memory address
mem_wdata  out  WORD_SIZE  memory write data
mem_we  out  1  memory write enable
mem_rdata  in  WORD_SIZE  synchronous read data, valid the cycle after mem_addr

Behaviour:
States: RUN, DRAIN, HOST_IDLE, HOST_ACCESS, COOLDOWN. A cooldown counter of clog2(MIN_CPU_CYCLES+1) bits, minimum 1 bit, supports COOLDOWN.

Reset (async, any state):
- state = RUN, counter = 0.
- cpu_halt = 0, host_grant = 0, host_ack = 0, host_rdata = 0.
- An in-flight host access is dropped with no ack.

Memory mux:
- In RUN, DRAIN and COOLDOWN: mem_addr = cpu_addr, mem_wdata = cpu_wdata, mem_we = !cpu_load.
- In HOST_IDLE:
  - mem_addr = host_addr, mem_wdata = host_wdata.
  - mem_we = issue && host_we, where issue = host_req && !host_ack.
- In HOST_ACCESS: mem_addr = host_addr, mem_we = 0.
- CPU stores are never forwarded in host states.

Status outputs:
- cpu_halt = 1 in DRAIN, HOST_IDLE and HOST_ACCESS.
- host_grant = 1 in HOST_IDLE and HOST_ACCESS.

Transitions:
- RUN: host_req -> DRAIN.
- DRAIN:
  - The CPU completes its current instruction, including a store, because the mux still follows the CPU.
  - cpu_halted -> HOST_IDLE. If cpu_halted is already 1 on entry, DRAIN lasts exactly 1 cycle.
  - Dropping host_req in DRAIN does not abort; the arbiter proceeds to HOST_IDLE.
- HOST_IDLE:
  - issue -> HOST_ACCESS; a write commits at the end of this cycle.
  - !host_req and !host_ack -> COOLDOWN with counter = MIN_CPU_CYCLES, or directly to RUN if MIN_CPU_CYCLES = 0.
  - Otherwise (ack cycle) stay.
- HOST_ACCESS:
  - Always -> HOST_IDLE.
  - At the end of this cycle, host_ack <= 1 for exactly one cycle.
  - On reads only, host_rdata <= mem_rdata. Writes leave host_rdata unchanged.
- Per-access timing:
  - Cadence is 2 cycles issue-to-ack; back-to-back accesses every 3 cycles.
  - The host must update or drop host_req during the ack cycle; the arbiter ignores host_req while host_ack = 1.
- COOLDOWN:
  - The counter decrements each cycle; -> RUN when the counter reaches 1.
  - host_req is ignored, so the CPU gets exactly MIN_CPU_CYCLES unhalted cycles.
- host_ack is 0 in every state other than the cycle after HOST_ACCESS.
- cpu_halted arriving while not in DRAIN has no effect.

Test Plan:
1. Reset: areset pulsed mid-HOST_ACCESS -> state RUN, host_ack stays 0, host_rdata = 0, cpu_halt = 0, and the mux follows the CPU on the first post-reset cycle.
2. CPU pass-through: in RUN with cpu_addr = 0x0010, cpu_load = 0, cpu_wdata = 0x1234 -> mem_addr = 0x0010, mem_we = 1, mem_wdata = 0x1234. With mem_rdata = 0xBEEF, cpu_rdata = 0xBEEF.
3. Host write then read:
   - Halt handshake: host_req = 1 -> cpu_halt = 1 the next cycle; cpu_halted raised 3 cycles later -> host_grant = 1 the next cycle.
   - Write: host_we = 1, host_addr = 0x0005, host_wdata = 0x00AA -> mem_we = 1 for exactly one cycle, host_ack 2 cycles after issue.
   - Read: read of 0x0005 with the memory model returning 0x00AA -> host_rdata = 0x00AA together with host_ack.
4. Store during drain: host_req raised while the CPU is in a store cycle (cpu_load = 0, addr 0x0020) -> the memory write to 0x0020 occurs. Once in HOST_IDLE, cpu_load = 0 produces no mem_we.
5. Cooldown window (MIN_CPU_CYCLES = 4):
   - Host drops req -> cpu_halt = 0 for exactly 4 cycles even with host_req reasserted immediately, then DRAIN.
   - With MIN_CPU_CYCLES = 0 -> RUN directly, and DRAIN starts on the next cycle.
6. Ack gating: host holds host_req = 1 through the ack cycle -> the second access issues the cycle after the ack, never during it. Three consecutive reads yield acks spaced exactly 3 cycles apart.

Source files
------------

// File: rtl/subleq_mem_arbiter_if.sv
// rtl/subleq_mem_arbiter_if.sv - CPU, host and memory signals of the subleq memory arbiter
interface subleq_mem_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    logic                 cpu_halt;
    logic                 cpu_halted;
    logic                 cpu_load;
    logic [WORD_SIZE-1:0] cpu_addr;
    logic [WORD_SIZE-1:0] cpu_wdata;
    logic [WORD_SIZE-1:0] cpu_rdata;

    logic                 host_req;
    logic                 host_we;
    logic [WORD_SIZE-1:0] host_addr;
    logic [WORD_SIZE-1:0] host_wdata;
    logic                 host_grant;
    logic                 host_ack;
    logic [WORD_SIZE-1:0] host_rdata;

    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport master (
        output cpu_halt, cpu_rdata, host_grant, host_ack, host_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  cpu_halted, cpu_load, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata, mem_rdata
    );

    modport slave (
        input  cpu_halt, cpu_rdata, host_grant, host_ack, host_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output cpu_halted, cpu_load, cpu_addr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata, mem_rdata
    );
endinterface

// File: rtl/subleq_mem_arbiter.sv
// rtl/subleq_mem_arbiter.sv - shares the subleq single-port memory between the CPU and a host port
module subleq_mem_arbiter #(
    parameter int WORD_SIZE      = 16,
    parameter int MIN_CPU_CYCLES = 4
) (
    input logic                  clk,
    input logic                  areset,
    subleq_mem_arbiter_if.master bus
);
    localparam int CW = (MIN_CPU_CYCLES > 0) ? $clog2(MIN_CPU_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        HOST_IDLE,
        HOST_ACCESS,
        COOLDOWN
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_dec;
    logic                 cpu_halt_q, host_grant_q, host_ack_q;
    logic [WORD_SIZE-1:0] host_rdata_q, host_rdata_d;
    logic                 issue;

    // The ack cycle masks host_req so a held request cannot re-issue early.
    assign issue   = bus.host_req && !host_ack_q;
    assign cnt_dec = cnt_q - CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (bus.host_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (bus.cpu_halted) state_d = HOST_IDLE;
            end
            HOST_IDLE: begin
                if (issue) begin
                    state_d = HOST_ACCESS;
                end else if (!bus.host_req && !host_ack_q) begin
                    if (MIN_CPU_CYCLES == 0) begin
                        state_d = RUN;
                    end else begin
                        state_d = COOLDOWN;
                        cnt_d   = CW'(MIN_CPU_CYCLES);
                    end
                end
            end
            HOST_ACCESS: begin
                state_d = HOST_IDLE;
            end
            COOLDOWN: begin
                // Leaving on the decrement to 1 counts the RUN cycle into the window.
                cnt_d = cnt_dec;
                if (cnt_dec <= CW'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_we    = !bus.cpu_load;
        if (state_q == HOST_IDLE || state_q == HOST_ACCESS) begin
            bus.mem_addr  = bus.host_addr;
            bus.mem_wdata = bus.host_wdata;
            bus.mem_we    = (state_q == HOST_IDLE) && issue && bus.host_we;
        end
    end

    assign host_rdata_d = (state_q == HOST_ACCESS && !bus.host_we) ? bus.mem_rdata : host_rdata_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            cpu_halt_q   <= 1'b0;
            host_grant_q <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cpu_halt_q   <= (state_d == DRAIN) || (state_d == HOST_IDLE) || (state_d == HOST_ACCESS);
            host_grant_q <= (state_d == HOST_IDLE) || (state_d == HOST_ACCESS);
            host_ack_q   <= (state_q == HOST_ACCESS);
            host_rdata_q <= host_rdata_d;
        end
    end

    assign bus.cpu_halt   = cpu_halt_q;
    assign bus.host_grant = host_grant_q;
    assign bus.host_ack   = host_ack_q;
    assign bus.host_rdata = host_rdata_q;
    assign bus.cpu_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// tb/tb_subleq_mem_arbiter.sv - randomized self-checking bench for subleq_mem_arbiter
module tb_subleq_mem_arbiter;
    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    subleq_mem_arbiter_if #(.WORD_SIZE(16)) bus4 ();
    subleq_mem_arbiter_if #(.WORD_SIZE(16)) bus0 ();

    subleq_mem_arbiter #(.WORD_SIZE(16), .MIN_CPU_CYCLES(4)) dut4 (
        .clk(clk), .areset(areset), .bus(bus4.master)
    );
    subleq_mem_arbiter #(.WORD_SIZE(16), .MIN_CPU_CYCLES(0)) dut0 (
        .clk(clk), .areset(areset), .bus(bus0.master)
    );

    // memory macro: synchronous read, one word per cycle
    logic [15:0] mem [0:255];
    logic [15:0] mem_q;
    logic        mem_clear;
    logic        force_rd;
    logic [15:0] force_val;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
            mem_q <= 16'h0;
        end else begin
            if (bus4.mem_we) mem[bus4.mem_addr[7:0]] <= bus4.mem_wdata;
            mem_q <= mem[bus4.mem_addr[7:0]];
        end
    end
    assign bus4.mem_rdata = force_rd ? force_val : mem_q;
    assign bus0.mem_rdata = 16'h0;

    // reference: what memory must hold, and what the last host read returned
    logic [15:0] ref_mem [0:255];
    logic [15:0] last_rd;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cpu_random(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus4.cpu_load  = 1'($urandom_range(0, 1));
            bus4.cpu_addr  = 16'($urandom_range(0, 63));
            bus4.cpu_wdata = 16'($urandom);
            #1;
            check("cpu_addr", 32'(bus4.mem_addr), 32'(bus4.cpu_addr));
            check("cpu_we", 32'(bus4.mem_we), 32'(!bus4.cpu_load));
            check("cpu_wdata", 32'(bus4.mem_wdata), 32'(bus4.cpu_wdata));
            check("cpu_rdata", 32'(bus4.cpu_rdata), 32'(bus4.mem_rdata));
            if (!bus4.cpu_load) ref_mem[bus4.cpu_addr[7:0]] = bus4.cpu_wdata;
        end
        @(negedge clk);
        bus4.cpu_load = 1'b1;
    endtask

    task automatic acquire(input int dly, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        int n;
        bus4.host_we    = we;
        bus4.host_addr  = addr;
        bus4.host_wdata = wdata;
        bus4.host_req   = 1'b1;
        @(negedge clk);
        check("halt_asserted", 32'(bus4.cpu_halt), 32'd1);
        check("grant_early", 32'(bus4.host_grant), 32'd0);
        repeat (dly) @(negedge clk);
        bus4.cpu_halted = 1'b1;
        n = 0;
        while (!bus4.host_grant && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("grant_latency", n, 1);
    endtask

    task automatic xfer(input logic we, input logic [15:0] addr, input logic [15:0] wdata, output int ack_cyc);
        int n;
        bus4.host_we    = we;
        bus4.host_addr  = addr;
        bus4.host_wdata = wdata;
        bus4.host_req   = 1'b1;
        #1;
        if (bus4.host_ack) begin
            check("ack_gate_we", 32'(bus4.mem_we), 32'd0);
            @(negedge clk);
            #1;
        end
        check("issue_we", 32'(bus4.mem_we), 32'(we));
        check("issue_addr", 32'(bus4.mem_addr), 32'(addr));
        n = 0;
        do begin
            @(negedge clk);
            n++;
            check("we_single", 32'(bus4.mem_we), 32'd0);
        end while (!bus4.host_ack && n < 6);
        check("ack_latency", n, 2);
        ack_cyc = cyc;
        if (!we) begin
            last_rd = ref_mem[addr[7:0]];
            check("host_rdata", 32'(bus4.host_rdata), 32'(last_rd));
        end else begin
            ref_mem[addr[7:0]] = wdata;
            check("rdata_hold", 32'(bus4.host_rdata), 32'(last_rd));
        end
    endtask

    task automatic release_host();
        int n;
        int exp;
        exp = bus4.host_ack ? 2 : 1;
        bus4.host_req = 1'b0;
        n = 0;
        while (bus4.cpu_halt && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("release_latency", n, exp);
        bus4.cpu_halted = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, k, z;
        logic we;
        logic [15:0] a, d;

        areset = 1'b1; mem_clear = 1'b1; force_rd = 1'b0; force_val = 16'h0; last_rd = 16'h0;
        bus4.cpu_halted = 1'b0; bus4.cpu_load = 1'b1; bus4.cpu_addr = 16'h0; bus4.cpu_wdata = 16'h0;
        bus4.host_req = 1'b0; bus4.host_we = 1'b0; bus4.host_addr = 16'h0; bus4.host_wdata = 16'h0;
        bus0.cpu_halted = 1'b0; bus0.cpu_load = 1'b1; bus0.cpu_addr = 16'h0; bus0.cpu_wdata = 16'h0;
        bus0.host_req = 1'b0; bus0.host_we = 1'b0; bus0.host_addr = 16'h0; bus0.host_wdata = 16'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_halt", 32'(bus4.cpu_halt), 32'd0);
        check("rst_grant", 32'(bus4.host_grant), 32'd0);
        check("rst_ack", 32'(bus4.host_ack), 32'd0);
        check("rst_rdata", 32'(bus4.host_rdata), 32'd0);
        areset = 1'b0; mem_clear = 1'b0;

        // CPU pass-through
        @(negedge clk);
        bus4.cpu_addr = 16'h0010; bus4.cpu_load = 1'b0; bus4.cpu_wdata = 16'h1234;
        force_rd = 1'b1; force_val = 16'hBEEF;
        #1;
        check("pt_addr", 32'(bus4.mem_addr), 32'h0010);
        check("pt_we", 32'(bus4.mem_we), 32'd1);
        check("pt_wdata", 32'(bus4.mem_wdata), 32'h1234);
        check("pt_rdata", 32'(bus4.cpu_rdata), 32'hBEEF);
        ref_mem[8'h10] = 16'h1234;
        @(negedge clk);
        force_rd = 1'b0; bus4.cpu_load = 1'b1;

        // random CPU traffic interleaved with random host bursts
        for (int b = 0; b < 6; b++) begin
            cpu_random(6);
            k  = int'($urandom_range(1, 4));
            we = 1'($urandom_range(0, 1));
            a  = 16'($urandom_range(0, 63));
            d  = 16'($urandom);
            acquire(int'($urandom_range(0, 4)), we, a, d);
            xfer(we, a, d, t0);
            for (int j = 1; j < k; j++) begin
                we = 1'($urandom_range(0, 1));
                a  = 16'($urandom_range(0, 63));
                d  = 16'($urandom);
                xfer(we, a, d, t1);
                check("burst_spacing", t1 - t0, 3);
                t0 = t1;
            end
            release_host();
        end
        cpu_random(6);

        // host write then read back, three back-to-back reads
        acquire(3, 1'b1, 16'h0005, 16'h00AA);
        xfer(1'b1, 16'h0005, 16'h00AA, t0);
        xfer(1'b0, 16'h0005, 16'h0000, t0);
        check("rd_0005", 32'(bus4.host_rdata), 32'h00AA);
        xfer(1'b0, 16'h0005, 16'h0000, t1);
        xfer(1'b0, 16'h0010, 16'h0000, t2);
        check("read_spacing_1", t1 - t0, 3);
        check("read_spacing_2", t2 - t1, 3);

        // cooldown window with the request reasserted at once
        release_host();
        bus4.host_req = 1'b1; bus4.host_we = 1'b0; bus4.host_addr = 16'h0005;
        z = 0;
        while (!bus4.cpu_halt && z < 20) begin
            z++;
            @(negedge clk);
        end
        check("cooldown_len", z, 4);
        check("cooldown_drain_grant", 32'(bus4.host_grant), 32'd0);
        bus4.cpu_halted = 1'b1;
        @(negedge clk);
        check("cooldown_grant", 32'(bus4.host_grant), 32'd1);
        xfer(1'b0, 16'h0005, 16'h0000, t0);
        release_host();
        cpu_random(6);

        // CPU store in flight while the drain starts
        bus4.cpu_load = 1'b0; bus4.cpu_addr = 16'h0020; bus4.cpu_wdata = 16'h5A5A;
        bus4.host_req = 1'b1; bus4.host_we = 1'b0; bus4.host_addr = 16'h0020; bus4.host_wdata = 16'h0;
        #1;
        check("drain_store_we", 32'(bus4.mem_we), 32'd1);
        ref_mem[8'h20] = 16'h5A5A;
        @(negedge clk);
        check("drain_halt", 32'(bus4.cpu_halt), 32'd1);
        check("drain_we", 32'(bus4.mem_we), 32'd1);
        check("drain_addr", 32'(bus4.mem_addr), 32'h0020);
        bus4.cpu_halted = 1'b1;
        @(negedge clk);
        check("drain_grant", 32'(bus4.host_grant), 32'd1);
        bus4.cpu_addr = 16'h0030; bus4.cpu_wdata = 16'hDEAD;
        #1;
        check("no_cpu_store", 32'(bus4.mem_we), 32'd0);
        xfer(1'b0, 16'h0020, 16'h0000, t0);
        xfer(1'b0, 16'h0030, 16'h0000, t0);
        bus4.cpu_load = 1'b1;
        release_host();
        cpu_random(6);

        // reset while a host read is in its access cycle
        acquire(0, 1'b1, 16'h0007, 16'hA5A5);
        xfer(1'b1, 16'h0007, 16'hA5A5, t0);
        xfer(1'b0, 16'h0007, 16'h0000, t0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_grant", 32'(bus4.host_grant), 32'd1);
        check("pre_rst_ack", 32'(bus4.host_ack), 32'd0);
        areset = 1'b1;
        bus4.host_req = 1'b0; bus4.cpu_halted = 1'b0; bus4.cpu_load = 1'b1; bus4.cpu_addr = 16'h0033;
        #1;
        check("arst_halt", 32'(bus4.cpu_halt), 32'd0);
        check("arst_grant", 32'(bus4.host_grant), 32'd0);
        check("arst_ack", 32'(bus4.host_ack), 32'd0);
        check("arst_rdata", 32'(bus4.host_rdata), 32'd0);
        @(negedge clk);
        check("arst_ack_hold", 32'(bus4.host_ack), 32'd0);
        areset = 1'b0;
        last_rd = 16'h0;
        #1;
        check("post_rst_addr", 32'(bus4.mem_addr), 32'h0033);
        check("post_rst_we", 32'(bus4.mem_we), 32'd0);
        @(negedge clk);
        check("post_rst_ack", 32'(bus4.host_ack), 32'd0);
        check("post_rst_halt", 32'(bus4.cpu_halt), 32'd0);

        // zero-length cooldown
        @(negedge clk);
        bus0.host_req = 1'b1;
        @(negedge clk);
        check("m0_halt", 32'(bus0.cpu_halt), 32'd1);
        bus0.cpu_halted = 1'b1;
        @(negedge clk);
        check("m0_grant", 32'(bus0.host_grant), 32'd1);
        bus0.host_req = 1'b0;
        @(negedge clk);
        check("m0_run_halt", 32'(bus0.cpu_halt), 32'd0);
        check("m0_run_grant", 32'(bus0.host_grant), 32'd0);
        bus0.host_req = 1'b1; bus0.cpu_halted = 1'b0;
        @(negedge clk);
        check("m0_drain_halt", 32'(bus0.cpu_halt), 32'd1);
        check("m0_drain_grant", 32'(bus0.host_grant), 32'd0);
        bus0.host_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
